// File: rtl/rv32i_ex_mem_reg.sv
// rv32i_ex_mem_reg: EX/MEM pipeline register of the RV32I 5-stage core.
// It captures the EX-stage results on every rising edge and presents them
// to the MEM stage. It supports stall (hold), flush (bubble insertion) and
// a per-entry valid bit.
// Edge priority: reset > flush > stall > load.
// An entry loaded with VALID_IN=0 has its controls cleared and its
// instruction replaced by NOP_INST, so it can never store, branch or write
// a register.
// Optional build macro RV32I_PIPE_STATS_EN adds bubble and stall event
// counters (BUBBLE_CNT_OUT, STALL_CNT_OUT).
module rv32i_ex_mem_reg #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_INST = 32'h00000013
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              STALL_IN,
  input  logic              FLUSH_IN,
  input  logic              VALID_IN,
  input  logic [1:0]        CTRL_WB_IN,
  input  logic [2:0]        CTRL_MEM_IN,
  input  logic [DATA_W-1:0] PCIMM_IN,
  input  logic [2:0]        COMPARE_IN,
  input  logic [DATA_W-1:0] ALURESULT_IN,
  input  logic [DATA_W-1:0] REG2_IN,
  input  logic [DATA_W-1:0] INST_IN,
  output logic              VALID_OUT,
  output logic [1:0]        CTRL_WB_OUT,
  output logic [2:0]        CTRL_MEM_OUT,
  output logic [DATA_W-1:0] PCIMM_OUT,
  output logic [2:0]        COMPARE_OUT,
  output logic [DATA_W-1:0] ALURESULT_OUT,
  output logic [DATA_W-1:0] REG2_OUT,
  output logic [DATA_W-1:0] INST_OUT
`ifdef RV32I_PIPE_STATS_EN
  ,
  output logic [31:0]       BUBBLE_CNT_OUT,
  output logic [31:0]       STALL_CNT_OUT
`endif
);

  logic              valid_q,     valid_d;
  logic [1:0]        ctrl_wb_q,   ctrl_wb_d;
  logic [2:0]        ctrl_mem_q,  ctrl_mem_d;
  logic [DATA_W-1:0] pcimm_q,     pcimm_d;
  logic [2:0]        compare_q,   compare_d;
  logic [DATA_W-1:0] aluresult_q, aluresult_d;
  logic [DATA_W-1:0] reg2_q,      reg2_d;
  logic [DATA_W-1:0] inst_q,      inst_d;

  // Next-entry selection: flush beats stall, stall beats load.
  always_comb begin
    // NOTE: every output of this block gets a default first (hold), so no
    // path through the if/else can leave a value unassigned and infer a latch.
    valid_d     = valid_q;
    ctrl_wb_d   = ctrl_wb_q;
    ctrl_mem_d  = ctrl_mem_q;
    pcimm_d     = pcimm_q;
    compare_d   = compare_q;
    aluresult_d = aluresult_q;
    reg2_d      = reg2_q;
    inst_d      = inst_q;
    if (FLUSH_IN) begin
      valid_d     = 1'b0;
      ctrl_wb_d   = '0;
      ctrl_mem_d  = '0;
      pcimm_d     = '0;
      compare_d   = '0;
      aluresult_d = '0;
      reg2_d      = '0;
      inst_d      = NOP_INST;
    end else if (!STALL_IN) begin
      valid_d     = VALID_IN;
      pcimm_d     = PCIMM_IN;
      compare_d   = COMPARE_IN;
      aluresult_d = ALURESULT_IN;
      reg2_d      = REG2_IN;
      if (VALID_IN) begin
        ctrl_wb_d  = CTRL_WB_IN;
        ctrl_mem_d = CTRL_MEM_IN;
        inst_d     = INST_IN;
      end else begin
        // A non-valid entry must be side-effect free downstream.
        ctrl_wb_d  = '0;
        ctrl_mem_d = '0;
        inst_d     = NOP_INST;
      end
    end
  end

  // Pipeline register state; an asynchronous reset drops a bubble in at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the data fields are reset too, not only valid/controls, so a
      // reset entry is bit-identical to a flushed bubble.
      valid_q     <= 1'b0;
      ctrl_wb_q   <= '0;
      ctrl_mem_q  <= '0;
      pcimm_q     <= '0;
      compare_q   <= '0;
      aluresult_q <= '0;
      reg2_q      <= '0;
      inst_q      <= NOP_INST;
    end else begin
      // NOTE: non-blocking assignments keep every field sampling pre-edge values.
      valid_q     <= valid_d;
      ctrl_wb_q   <= ctrl_wb_d;
      ctrl_mem_q  <= ctrl_mem_d;
      pcimm_q     <= pcimm_d;
      compare_q   <= compare_d;
      aluresult_q <= aluresult_d;
      reg2_q      <= reg2_d;
      inst_q      <= inst_d;
    end
  end

  assign VALID_OUT     = valid_q;
  assign CTRL_WB_OUT   = ctrl_wb_q;
  assign CTRL_MEM_OUT  = ctrl_mem_q;
  assign PCIMM_OUT     = pcimm_q;
  assign COMPARE_OUT   = compare_q;
  assign ALURESULT_OUT = aluresult_q;
  assign REG2_OUT      = reg2_q;
  assign INST_OUT      = inst_q;

`ifdef RV32I_PIPE_STATS_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;

  // Event counting follows the data-path priority; a flush during a stall is a bubble only.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (FLUSH_IN || (!STALL_IN && !VALID_IN)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (STALL_IN) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter state; both counters wrap naturally at 2^32.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign BUBBLE_CNT_OUT = bubble_cnt_q;
  assign STALL_CNT_OUT  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_ex_mem_reg.sv
// Testbench for rv32i_ex_mem_reg.
// The main checks are a vector table of stimulus and expected-output records.
// Hand-written sequences cover reset, asynchronous reset, a random run and,
// when RV32I_PIPE_STATS_EN is defined, the event counters.
// Expected entries go through a scoreboard queue.
module tb_rv32i_ex_mem_reg;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] DB  = 32'hDEADBEEF;

  typedef struct packed {
    logic        valid;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] pcimm;
    logic [2:0]  cmp;
    logic [31:0] alu;
    logic [31:0] reg2;
    logic [31:0] inst;
  } ex_t;

  typedef struct {
    string name;
    logic  stall;
    logic  flush;
    ex_t   in;
    ex_t   exp;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        STALL_IN, FLUSH_IN, VALID_IN;
  logic [1:0]  CTRL_WB_IN;
  logic [2:0]  CTRL_MEM_IN, COMPARE_IN;
  logic [31:0] PCIMM_IN, ALURESULT_IN, REG2_IN, INST_IN;
  logic        VALID_OUT;
  logic [1:0]  CTRL_WB_OUT;
  logic [2:0]  CTRL_MEM_OUT, COMPARE_OUT;
  logic [31:0] PCIMM_OUT, ALURESULT_OUT, REG2_OUT, INST_OUT;
`ifdef RV32I_PIPE_STATS_EN
  logic [31:0] BUBBLE_CNT_OUT, STALL_CNT_OUT;
`endif

  int   checks = 0;
  int   errors = 0;
  ex_t  sb_q[$];
  ex_t  model_q;
  logic [31:0] m_bub, m_stl;
  vec_t vecs[14];

  rv32i_ex_mem_reg dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .STALL_IN      (STALL_IN),
    .FLUSH_IN      (FLUSH_IN),
    .VALID_IN      (VALID_IN),
    .CTRL_WB_IN    (CTRL_WB_IN),
    .CTRL_MEM_IN   (CTRL_MEM_IN),
    .PCIMM_IN      (PCIMM_IN),
    .COMPARE_IN    (COMPARE_IN),
    .ALURESULT_IN  (ALURESULT_IN),
    .REG2_IN       (REG2_IN),
    .INST_IN       (INST_IN),
    .VALID_OUT     (VALID_OUT),
    .CTRL_WB_OUT   (CTRL_WB_OUT),
    .CTRL_MEM_OUT  (CTRL_MEM_OUT),
    .PCIMM_OUT     (PCIMM_OUT),
    .COMPARE_OUT   (COMPARE_OUT),
    .ALURESULT_OUT (ALURESULT_OUT),
    .REG2_OUT      (REG2_OUT),
    .INST_OUT      (INST_OUT)
`ifdef RV32I_PIPE_STATS_EN
    ,
    .BUBBLE_CNT_OUT(BUBBLE_CNT_OUT),
    .STALL_CNT_OUT (STALL_CNT_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic ex_t mk(logic v, logic [1:0] wb, logic [2:0] mem, logic [31:0] pc,
                             logic [2:0] cmp, logic [31:0] alu, logic [31:0] r2, logic [31:0] inst);
    return '{valid: v, wb: wb, mem: mem, pcimm: pc, cmp: cmp, alu: alu, reg2: r2, inst: inst};
  endfunction

  function automatic ex_t bubble();
    return mk(1'b0, 2'b00, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0, NOP);
  endfunction

  function automatic ex_t rand_in();
    logic [31:0] r;
    r = $urandom;
    return mk(r[0], r[2:1], r[5:3], $urandom, r[8:6], $urandom, $urandom, $urandom);
  endfunction

  // Reference behaviour of one rising edge.
  function automatic ex_t predict(ex_t prev, logic st, logic fl, ex_t in);
    ex_t n;
    if (fl) n = bubble();
    else if (st) n = prev;
    else begin
      n = in;
      if (!in.valid) begin
        n.wb   = 2'b00;
        n.mem  = 3'b000;
        n.inst = NOP;
      end
    end
    return n;
  endfunction

  function automatic ex_t outs();
    return {VALID_OUT, CTRL_WB_OUT, CTRL_MEM_OUT, PCIMM_OUT, COMPARE_OUT,
            ALURESULT_OUT, REG2_OUT, INST_OUT};
  endfunction

  task automatic check(input string name, input ex_t act, input ex_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input ex_t in);
    STALL_IN     = st;
    FLUSH_IN     = fl;
    VALID_IN     = in.valid;
    CTRL_WB_IN   = in.wb;
    CTRL_MEM_IN  = in.mem;
    PCIMM_IN     = in.pcimm;
    COMPARE_IN   = in.cmp;
    ALURESULT_IN = in.alu;
    REG2_IN      = in.reg2;
    INST_IN      = in.inst;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare 1ns after the edge.
  task automatic apply(input string name, input logic st, input logic fl, input ex_t in, input ex_t exp);
    ex_t e;
    drive(st, fl, in);
    sb_q.push_back(exp);
    if (fl) m_bub = m_bub + 32'd1;
    else if (st) m_stl = m_stl + 32'd1;
    else if (!in.valid) m_bub = m_bub + 32'd1;
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check(name, outs(), e);
    model_q = exp;
  endtask

  task automatic step(input string name, input logic st, input logic fl, input ex_t in);
    apply(name, st, fl, in, predict(model_q, st, fl, in));
  endtask

  // Pulse reset between edges and check that the outputs clear before the next edge.
  task automatic pulse_reset(input string name);
    #2;
    RESET_N = 1'b0;
    #1;
    check({name, "_immediate"}, outs(), bubble());
    drive(1'b0, 1'b1, rand_in());
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check({name, "_after_release"}, outs(), bubble());
    model_q = bubble();
    m_bub   = 32'd1;
    m_stl   = 32'd0;
  endtask

  initial begin
    ex_t beq, i2, dd, inv, ld;
    ld  = mk(1'b1, 2'b10, 3'b010, 32'h100, 3'b010, 32'h1000, 32'h55, 32'h00002083);
    i2  = mk(1'b1, 2'b10, 3'b000, 32'h200, 3'b001, 32'hA, 32'h0, 32'h00A00093);
    dd  = mk(1'b1, 2'b11, 3'b001, DB, 3'b100, DB, DB, DB);
    beq = mk(1'b1, 2'b00, 3'b100, 32'h3000, 3'b010, 32'h0, 32'h0, 32'h00208463);
    inv = mk(1'b0, 2'b11, 3'b001, 32'hCAFE0000, 3'b111, 32'h1234, 32'h5678, 32'hFFFFFFFF);

    vecs[0]  = '{"load_lw",       1'b0, 1'b0, ld,  ld};
    vecs[1]  = '{"load_addi",     1'b0, 1'b0, i2,  i2};
    vecs[2]  = '{"stall_1",       1'b1, 1'b0, dd,  i2};
    vecs[3]  = '{"stall_2",       1'b1, 1'b0, dd,  i2};
    vecs[4]  = '{"stall_3",       1'b1, 1'b0, dd,  i2};
    vecs[5]  = '{"stall_release", 1'b0, 1'b0, dd,  dd};
    vecs[6]  = '{"load_beq",      1'b0, 1'b0, beq, beq};
    vecs[7]  = '{"flush_over_stall", 1'b1, 1'b1, dd, bubble()};
    vecs[8]  = '{"invalid_load",  1'b0, 1'b0, inv,
                 mk(1'b0, 2'b00, 3'b000, 32'hCAFE0000, 3'b111, 32'h1234, 32'h5678, NOP)};
    vecs[9]  = '{"flush_run_1",   1'b0, 1'b1, dd,  bubble()};
    vecs[10] = '{"flush_run_2",   1'b0, 1'b1, dd,  bubble()};
    vecs[11] = '{"flush_run_3",   1'b0, 1'b1, dd,  bubble()};
    vecs[12] = '{"reload_beq",    1'b0, 1'b0, beq, beq};
    vecs[13] = '{"stall_ignores_invalid", 1'b1, 1'b0, inv, beq};

    // Reset held with random inputs toggling underneath.
    RESET_N = 1'b0;
    drive(1'b0, 1'b0, rand_in());
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      check("reset_hold", outs(), bubble());
      drive(1'b0, 1'b0, rand_in());
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    model_q = bubble();
    m_bub   = 32'd0;
    m_stl   = 32'd0;

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].name, vecs[i].stall, vecs[i].flush, vecs[i].in, vecs[i].exp);
    end

    // Asynchronous reset while stalled.
    apply("pre_async_load", 1'b0, 1'b0, i2, i2);
    apply("pre_async_stall", 1'b1, 1'b0, dd, i2);
    pulse_reset("async_reset_mid_stall");

    // Random run against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = $urandom;
      step("random", (r[1:0] == 2'b00), (r[4:2] == 3'b000), rand_in());
    end

`ifdef RV32I_PIPE_STATS_EN
    check32("random_bubble_cnt", BUBBLE_CNT_OUT, m_bub);
    check32("random_stall_cnt", STALL_CNT_OUT, m_stl);

    // Counters are cleared by reset; the release edge is a flush, so start from a clean reset.
    pulse_reset("stats_reset");
    RESET_N = 1'b0;
    #1;
    RESET_N = 1'b1;
    m_bub = 32'd0;
    m_stl = 32'd0;
    model_q = bubble();
    step("stats_load", 1'b0, 1'b0, i2);
    step("stats_stall_1", 1'b1, 1'b0, dd);
    step("stats_stall_2", 1'b1, 1'b0, dd);
    step("stats_flush_1", 1'b0, 1'b1, dd);
    step("stats_flush_stall", 1'b1, 1'b1, dd);
    step("stats_flush_3", 1'b0, 1'b1, dd);
    check32("stall_cnt", STALL_CNT_OUT, 32'd2);
    check32("bubble_cnt", BUBBLE_CNT_OUT, 32'd3);

    // Wrap of the bubble counter.
    force dut.bubble_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.bubble_cnt_q;
    step("stats_wrap_flush", 1'b0, 1'b1, dd);
    check32("bubble_cnt_wrap", BUBBLE_CNT_OUT, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
